// File: rtl/flippin_bits_pkg.sv
// Shared types and constants for the score path: FSM states, BCD correction
// constants and the width of the score produced by the game state machine.
package flippin_bits_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_ADD_THRESHOLD = 5;
  localparam int BCD_ADD_VALUE     = 3;
  localparam int SCORE_WIDTH       = 8;

endpackage

// File: rtl/score_bcd_serial_if.sv
// Start/busy/done handshake and digit outputs of the serial BCD converter.
interface score_bcd_serial_if #(
  parameter int BIN_WIDTH = 8
);
  logic                 start;
  logic [BIN_WIDTH-1:0] binary_in;
  logic                 busy;
  logic                 done;
  logic [3:0]           ones;
  logic [3:0]           tens;
  logic [3:0]           hundreds;

  modport master (
    output start, binary_in,
    input  busy, done, ones, tens, hundreds
  );

  modport slave (
    input  start, binary_in,
    output busy, done, ones, tens, hundreds
  );
endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble nibble correction: digits of 5 or more get +3 before the shift.
module bcd_add3_digit
  import flippin_bits_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= 4'(BCD_ADD_THRESHOLD))
      adjusted = digit + 4'(BCD_ADD_VALUE);
  end

endmodule

// File: rtl/score_bcd_serial.sv
// Sequential double-dabble converter: one shift per clock, result digits
// registered on the final shift and held until the next conversion finishes.
module score_bcd_serial
  import flippin_bits_pkg::*;
#(
  parameter int BIN_WIDTH = SCORE_WIDTH,
  parameter int DIGITS    = 3
) (
  input  logic               clock,
  input  logic               reset_signal,
  score_bcd_serial_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  state_t               state;
  state_t               state_next;
  logic [BIN_WIDTH-1:0] shift_reg;
  logic [BIN_WIDTH-1:0] shift_next;
  logic [BCD_W-1:0]     bcd;
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     bcd_next;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           ones;
  logic [3:0]           tens;
  logic [3:0]           hundreds;
  logic                 accept;
  logic                 last;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit    (bcd[4*d +: 4]),
      .adjusted (bcd_adj[4*d +: 4])
    );
  end

  assign {bcd_next, shift_next} = {bcd_adj, shift_reg} << 1;
  assign last   = (cnt == CNT_W'(BIN_WIDTH - 1));
  // DONE accepts a new request as well, giving back-to-back conversions.
  assign accept = bus.start && (state != SHIFT);

  always_ff @(posedge clock) begin
    if (reset_signal)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last)      state_next = DONE;
      DONE:    state_next = bus.start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      shift_reg <= '0;
      bcd       <= '0;
      cnt       <= '0;
      ones      <= '0;
      tens      <= '0;
      hundreds  <= '0;
    end else if (accept) begin
      shift_reg <= bus.binary_in;
      bcd       <= '0;
      cnt       <= '0;
    end else if (state == SHIFT) begin
      shift_reg <= shift_next;
      bcd       <= bcd_next;
      cnt       <= cnt + CNT_W'(1);
      if (last) begin
        ones     <= bcd_next[3:0];
        tens     <= bcd_next[7:4];
        hundreds <= bcd_next[11:8];
      end
    end
  end

  assign bus.busy     = (state == SHIFT);
  assign bus.done     = (state == DONE);
  assign bus.ones     = ones;
  assign bus.tens     = tens;
  assign bus.hundreds = hundreds;

endmodule
